// File: rtl/pwm_capture_if.sv
// Register-side bundle of the PWM input-capture peripheral: configuration in, results out.
// The master side programs the block and reads results; the slave side is the capture unit.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [CNT_W-1:0] prescaler;
    logic             polarity;
    logic             clr_timeout;
    logic             cap_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] pulse;
    logic             valid;
    logic             timeout;
    logic             active;

    modport master (
        output en, prescaler, polarity, clr_timeout, cap_in,
        input  period, pulse, valid, timeout, active
    );

    modport slave (
        input  en, prescaler, polarity, clr_timeout, cap_in,
        output period, pulse, valid, timeout, active
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and active width of cap_in in prescaled ticks,
// with a one-cycle result strobe and a sticky timeout for stuck or absent signals.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    pwm_capture_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state, state_nxt;
    logic             sync1, sync2, s_d;
    logic             s, rise, fall;
    logic [CNT_W-1:0] div, div_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, nxt;
    logic [CNT_W-1:0] pulse_tmp, pulse_tmp_nxt;
    logic [CNT_W-1:0] period_q, pulse_q;
    logic             valid_q, timeout_q, active_q;
    logic             tick, sat, capture, set_to;

    assign s    = sync2 ^ bus.polarity;
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
    assign tick = (div == bus.prescaler);
    // Captured values include a tick landing in the edge cycle itself.
    assign nxt  = cnt + CNT_W'(tick);
    assign sat  = (cnt == '1) && tick;

    always_comb begin
        state_nxt     = state;
        div_nxt       = tick ? '0 : div + CNT_W'(1);
        cnt_nxt       = nxt;
        pulse_tmp_nxt = pulse_tmp;
        capture       = 1'b0;
        set_to        = 1'b0;
        if (!bus.en) begin
            state_nxt     = IDLE;
            div_nxt       = '0;
            cnt_nxt       = '0;
            pulse_tmp_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    div_nxt = '0;
                    cnt_nxt = '0;
                    if (rise) state_nxt = HIGH;
                end
                HIGH: begin
                    if (sat) begin
                        state_nxt = IDLE;
                        set_to    = 1'b1;
                    end else if (fall) begin
                        state_nxt     = LOW;
                        pulse_tmp_nxt = nxt;
                    end
                end
                LOW: begin
                    if (sat) begin
                        state_nxt = IDLE;
                        set_to    = 1'b1;
                    end else if (rise) begin
                        // Closing rise also opens the next period, so no cycles are lost.
                        state_nxt = HIGH;
                        capture   = 1'b1;
                        div_nxt   = '0;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            s_d       <= 1'b0;
            div       <= '0;
            cnt       <= '0;
            pulse_tmp <= '0;
            period_q  <= '0;
            pulse_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            sync1     <= bus.cap_in;
            sync2     <= sync1;
            s_d       <= s;
            div       <= div_nxt;
            cnt       <= cnt_nxt;
            pulse_tmp <= pulse_tmp_nxt;
            valid_q   <= capture;
            if (capture) begin
                period_q <= nxt;
                pulse_q  <= pulse_tmp;
            end
            if (set_to)
                timeout_q <= 1'b1;
            else if (bus.clr_timeout)
                timeout_q <= 1'b0;
            active_q  <= (state != IDLE);
        end
    end

    assign bus.period  = period_q;
    assign bus.pulse   = pulse_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
    assign bus.active  = active_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives pin trains and compares results against
// floor(clocks / (prescaler+1)) computed from the generated waveform.
module tb_pwm_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    pwm_capture_if #(.CNT_W(16)) bus ();

    pwm_capture #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int q_period[$];
    int q_pulse[$];
    int q_stamp[$];

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            q_period.push_back(int'(bus.period));
            q_pulse.push_back(int'(bus.pulse));
            q_stamp.push_back(cyc);
        end
    end

    int hs[16];
    int ls[16];
    int last_period = 0;
    int last_pulse  = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pin holds level v for exactly n sampling edges.
    task automatic hold(input logic v, input int n);
        bus.cap_in = v;
        step(n);
    endtask

    task automatic flush();
        q_period.delete();
        q_pulse.delete();
        q_stamp.delete();
    endtask

    task automatic setup(input int p, input logic pol);
        bus.en        = 1'b0;
        bus.prescaler = 16'(p);
        bus.polarity  = pol;
        bus.cap_in    = pol;
        step(4);
        flush();
        bus.en = 1'b1;
        step(4);
    endtask

    task automatic run_train(input int p, input logic pol, input int n, input string tag);
        int rise_at[17];
        int ep, eu;
        setup(p, pol);
        for (int i = 0; i < n; i++) begin
            rise_at[i] = cyc;
            hold(~pol, hs[i]);
            hold(pol, ls[i]);
        end
        rise_at[n] = cyc;
        hold(~pol, 2);
        step(4);
        n_total++;
        if (q_period.size() !== n)
            $display("FAIL %s count: got %0d expected %0d", tag, q_period.size(), n);
        else
            n_pass++;
        for (int i = 0; i < n && i < q_period.size(); i++) begin
            ep = (hs[i] + ls[i]) / (p + 1);
            eu = hs[i] / (p + 1);
            n_total++;
            if (q_period[i] !== ep)
                $display("FAIL %s period[%0d]: got %0d expected %0d", tag, i, q_period[i], ep);
            else
                n_pass++;
            n_total++;
            if (q_pulse[i] !== eu)
                $display("FAIL %s pulse[%0d]: got %0d expected %0d", tag, i, q_pulse[i], eu);
            else
                n_pass++;
            n_total++;
            if (q_stamp[i] !== rise_at[i+1] + 3)
                $display("FAIL %s valid_cycle[%0d]: got %0d expected %0d", tag, i, q_stamp[i], rise_at[i+1] + 3);
            else
                n_pass++;
            last_period = ep;
            last_pulse  = eu;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        n_total++; if (bus.period !== 16'd0) $display("FAIL reset_period: got %0d expected 0", bus.period); else n_pass++;
        n_total++; if (bus.pulse !== 16'd0) $display("FAIL reset_pulse: got %0d expected 0", bus.pulse); else n_pass++;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", bus.valid); else n_pass++;
        n_total++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %0b expected 0", bus.timeout); else n_pass++;
        n_total++; if (bus.active !== 1'b0) $display("FAIL reset_active: got %0b expected 0", bus.active); else n_pass++;
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) begin hs[i] = 3; ls[i] = 5; end
        run_train(0, 1'b0, 5, "basic");
    endtask

    task automatic test_prescale();
        for (int i = 0; i < 3; i++) begin hs[i] = 4; ls[i] = 4; end
        run_train(1, 1'b0, 3, "prescale");
        run_train(1, 1'b1, 3, "prescale_inv");
    endtask

    task automatic test_en_toggle();
        int rb;
        setup(0, 1'b0);
        hold(1'b1, 4);
        bus.en = 1'b0;
        hold(1'b1, 4);
        hold(1'b0, 8);
        hold(1'b1, 4);
        bus.en = 1'b1;
        hold(1'b1, 4);
        hold(1'b0, 8);
        hold(1'b1, 6);
        hold(1'b0, 6);
        rb = cyc;
        hold(1'b1, 2);
        step(4);
        n_total++;
        if (q_period.size() !== 1) $display("FAIL en_toggle count: got %0d expected 1", q_period.size()); else n_pass++;
        if (q_period.size() > 0) begin
            n_total++; if (q_period[0] !== 12) $display("FAIL en_toggle period: got %0d expected 12", q_period[0]); else n_pass++;
            n_total++; if (q_pulse[0] !== 6) $display("FAIL en_toggle pulse: got %0d expected 6", q_pulse[0]); else n_pass++;
            n_total++; if (q_stamp[0] !== rb + 3) $display("FAIL en_toggle valid_cycle: got %0d expected %0d", q_stamp[0], rb + 3); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int ry;
        setup(0, 1'b0);
        hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 3); hold(1'b0, 5);
        hold(1'b1, 3); hold(1'b0, 4);
        n_total++; if (bus.period !== 16'd8) $display("FAIL rmid_held_period: got %0d expected 8", bus.period); else n_pass++;
        n_total++; if (bus.pulse !== 16'd3) $display("FAIL rmid_held_pulse: got %0d expected 3", bus.pulse); else n_pass++;
        rst = 1'b1;
        step(1);
        n_total++; if (bus.period !== 16'd0) $display("FAIL rmid_period: got %0d expected 0", bus.period); else n_pass++;
        n_total++; if (bus.pulse !== 16'd0) $display("FAIL rmid_pulse: got %0d expected 0", bus.pulse); else n_pass++;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL rmid_valid: got %0b expected 0", bus.valid); else n_pass++;
        n_total++; if (bus.active !== 1'b0) $display("FAIL rmid_active: got %0b expected 0", bus.active); else n_pass++;
        rst = 1'b0;
        flush();
        hold(1'b0, 3);
        hold(1'b1, 3); hold(1'b0, 5);
        ry = cyc;
        hold(1'b1, 2);
        step(4);
        n_total++;
        if (q_period.size() !== 1) $display("FAIL rmid_count: got %0d expected 1", q_period.size()); else n_pass++;
        if (q_period.size() > 0) begin
            n_total++; if (q_period[0] !== 8) $display("FAIL rmid_first_period: got %0d expected 8", q_period[0]); else n_pass++;
            n_total++; if (q_pulse[0] !== 3) $display("FAIL rmid_first_pulse: got %0d expected 3", q_pulse[0]); else n_pass++;
            n_total++; if (q_stamp[0] !== ry + 3) $display("FAIL rmid_valid_cycle: got %0d expected %0d", q_stamp[0], ry + 3); else n_pass++;
        end
    endtask

    task automatic test_random();
        int p;
        logic pol;
        for (int it = 0; it < 3; it++) begin
            p   = $urandom_range(0, 3);
            pol = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                hs[i] = $urandom_range(1, 12);
                ls[i] = $urandom_range(1, 12);
            end
            run_train(p, pol, 4, $sformatf("random%0d_p%0d_pol%0d", it, p, pol));
        end
    endtask

    // Pin stuck high after one rise: saturation 65536 ticks after the rise cycle,
    // with clr_timeout colliding on the saturating edge.
    task automatic test_timeout();
        setup(0, 1'b0);
        hold(1'b1, 65538);
        n_total++; if (bus.timeout !== 1'b0) $display("FAIL timeout_early: got %0b expected 0", bus.timeout); else n_pass++;
        bus.clr_timeout = 1'b1;
        step(1);
        bus.clr_timeout = 1'b0;
        n_total++; if (bus.timeout !== 1'b1) $display("FAIL timeout_set_wins: got %0b expected 1", bus.timeout); else n_pass++;
        step(1);
        n_total++; if (bus.active !== 1'b0) $display("FAIL timeout_active: got %0b expected 0", bus.active); else n_pass++;
        n_total++; if (bus.timeout !== 1'b1) $display("FAIL timeout_sticky: got %0b expected 1", bus.timeout); else n_pass++;
        n_total++; if (q_period.size() !== 0) $display("FAIL timeout_no_valid: got %0d expected 0", q_period.size()); else n_pass++;
        n_total++; if (int'(bus.period) !== last_period) $display("FAIL timeout_period_held: got %0d expected %0d", bus.period, last_period); else n_pass++;
        n_total++; if (int'(bus.pulse) !== last_pulse) $display("FAIL timeout_pulse_held: got %0d expected %0d", bus.pulse, last_pulse); else n_pass++;
        bus.clr_timeout = 1'b1;
        step(1);
        bus.clr_timeout = 1'b0;
        n_total++; if (bus.timeout !== 1'b0) $display("FAIL timeout_clear: got %0b expected 0", bus.timeout); else n_pass++;
    endtask

    initial begin
        bus.en          = 1'b0;
        bus.prescaler   = '0;
        bus.polarity    = 1'b0;
        bus.clr_timeout = 1'b0;
        bus.cap_in      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_prescale();
        test_en_toggle();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
